sysref_edge_monitor: RTL and testbench

Consumes the registered PL SYSREF produced by the PL SYSREF capture stage and sits directly downstream of it, in the `pl_clk` domain. It detects SYSREF rising edges and emits a one-cycle aligned strobe per edge. It measures the edge-to-edge period, declares lock after a run of consistent periods, and reports period errors and loss of SYSREF. Downstream RF-ADC/DAC alignment logic uses `sysref_pulse` qualified by `locked`.

---
 rtl/sysref_edge_monitor.sv | 156 +++++++++++++++
 tb/tb_sysref_edge_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysref_edge_monitor.sv
// SYSREF rising-edge monitor: aligned strobe, period measurement, lock tracking,
// and sticky period-error / loss-of-SYSREF status, all in the pl_clk domain.
module sysref_edge_monitor #(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 1
) (
  input  logic                pl_clk,
  input  logic                reset_n,
  input  logic                sysref_in,
  input  logic                enable,
  input  logic                clear,
  output logic                sysref_pulse,
  output logic                locked,
  output logic [PERIOD_W-1:0] period,
  output logic                period_err,
  output logic                lost,
  output logic [15:0]         edge_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EC_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE,
    LOCKED
  } state_t;

  state_t               state, state_nx;
  logic                 sysref_d;
  logic [PERIOD_W-1:0]  cnt;
  logic [PERIOD_W-1:0]  ref_period, ref_period_nx;
  logic [MATCH_W-1:0]   match_cnt, match_cnt_nx;
  logic [MATCH_W-1:0]   match_inc_c;
  logic [PERIOD_W-1:0]  period_nx;
  logic                 period_err_nx, lost_nx, locked_nx;
  logic                 edge_c, accept_c, cnt_sat_c, timeout_c;
  logic                 ref_ok_c, period_ok_c;

  // Absolute difference without sign wrap: larger minus smaller.
  function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                   input logic [PERIOD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign edge_c      = sysref_in & ~sysref_d & enable;
  assign accept_c    = edge_c & ~clear & (state != IDLE);
  assign cnt_sat_c   = &cnt;
  assign timeout_c   = ({1'b0, cnt} == {period, 1'b0});
  assign match_inc_c = match_cnt + MATCH_W'(1);
  assign ref_ok_c    = ~cnt_sat_c & (abs_diff(cnt, ref_period) <= PERIOD_W'(TOL));
  assign period_ok_c = ~cnt_sat_c & (abs_diff(cnt, period) <= PERIOD_W'(TOL));

  // State register
  always_ff @(posedge pl_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state and status decisions; enable outranks clear, clear outranks edges
  always_comb begin
    state_nx      = state;
    ref_period_nx = ref_period;
    match_cnt_nx  = match_cnt;
    period_nx     = period;
    period_err_nx = period_err;
    lost_nx       = lost;

    if (clear) begin
      match_cnt_nx  = '0;
      period_err_nx = 1'b0;
      lost_nx       = 1'b0;
    end

    if (!enable) begin
      state_nx = IDLE;
    end else if (clear) begin
      state_nx = WAIT_FIRST;
    end else begin
      unique case (state)
        IDLE: state_nx = WAIT_FIRST;
        WAIT_FIRST: begin
          if (edge_c) begin
            state_nx     = MEASURE;
            match_cnt_nx = '0;
          end
        end
        MEASURE: begin
          if (edge_c) begin
            if (match_cnt == '0) begin
              ref_period_nx = cnt;
              match_cnt_nx  = MATCH_W'(1);
            end else if (ref_ok_c) begin
              match_cnt_nx = match_inc_c;
              if (match_inc_c == MATCH_W'(LOCK_COUNT)) begin
                state_nx  = LOCKED;
                period_nx = ref_period;
              end
            end else begin
              ref_period_nx = cnt;
              match_cnt_nx  = MATCH_W'(1);
            end
          end
        end
        LOCKED: begin
          if (edge_c) begin
            if (!period_ok_c) begin
              period_err_nx = 1'b1;
              state_nx      = MEASURE;
              ref_period_nx = cnt;
              match_cnt_nx  = MATCH_W'(1);
            end
          end else if (timeout_c) begin
            lost_nx  = 1'b1;
            state_nx = WAIT_FIRST;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    locked_nx = (state_nx == LOCKED);
  end

  // Datapath and registered outputs
  always_ff @(posedge pl_clk or negedge reset_n) begin
    if (!reset_n) begin
      sysref_d     <= 1'b0;
      cnt          <= '0;
      ref_period   <= '0;
      match_cnt    <= '0;
      sysref_pulse <= 1'b0;
      locked       <= 1'b0;
      period       <= '0;
      period_err   <= 1'b0;
      lost         <= 1'b0;
      edge_count   <= '0;
    end else begin
      sysref_d     <= sysref_in;
      ref_period   <= ref_period_nx;
      match_cnt    <= match_cnt_nx;
      sysref_pulse <= accept_c;
      locked       <= locked_nx;
      period       <= period_nx;
      period_err   <= period_err_nx;
      lost         <= lost_nx;
      if (edge_c)         cnt <= PERIOD_W'(1);
      else if (!cnt_sat_c) cnt <= cnt + PERIOD_W'(1);
      if (clear)         edge_count <= '0;
      else if (accept_c) edge_count <= edge_count + EC_W'(1);
    end
  end

endmodule

// File: tb/tb_sysref_edge_monitor.sv
// Self-checking bench for sysref_edge_monitor: interval-history model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_sysref_edge_monitor;

  localparam int PERIOD_W   = 16;
  localparam int LOCK_COUNT = 4;
  localparam int TOL        = 1;
  localparam int MAXC       = (1 << PERIOD_W) - 1;

  logic                pl_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                sysref_in = 1'b0;
  logic                enable = 1'b0;
  logic                clear = 1'b0;
  logic                sysref_pulse, locked, period_err, lost;
  logic [PERIOD_W-1:0] period;
  logic [15:0]         edge_count;

  int total = 0;
  int bad   = 0;

  sysref_edge_monitor #(.PERIOD_W(PERIOD_W), .LOCK_COUNT(LOCK_COUNT), .TOL(TOL)) dut (
    .pl_clk(pl_clk), .reset_n(reset_n), .sysref_in(sysref_in), .enable(enable),
    .clear(clear), .sysref_pulse(sysref_pulse), .locked(locked), .period(period),
    .period_err(period_err), .lost(lost), .edge_count(edge_count)
  );

  always #5 pl_clk = ~pl_clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edges stamped by cycle number, intervals kept in a run list
  int m_mode;  // 0 idle, 1 waiting for first edge, 2 measuring, 3 locked
  int cyc = 0, last_e = 1, m_period = 0, m_ec = 0;
  bit prev_in = 0, m_err = 0, m_lost = 0, m_pulse = 0;
  int run[$];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  always @(posedge pl_clk or negedge reset_n) begin
    int age;
    bit e, acc;
    if (!reset_n) begin
      m_mode = 0; last_e = cyc + 1; prev_in = 0; run.delete();
      m_period = 0; m_err = 0; m_lost = 0; m_pulse = 0; m_ec = 0;
    end else begin
      cyc++;
      age = cyc - last_e;
      if (age > MAXC) age = MAXC;
      e = sysref_in && !prev_in && enable;
      prev_in = sysref_in;
      acc = e && !clear && (m_mode != 0);
      m_pulse = acc;
      if (acc) m_ec = (m_ec + 1) % 65536;
      if (e) last_e = cyc;
      if (clear) begin
        m_err = 0; m_lost = 0; m_ec = 0; run.delete();
      end
      if (!enable) m_mode = 0;
      else if (clear) m_mode = 1;
      else begin
        case (m_mode)
          0: m_mode = 1;
          1: if (e) begin m_mode = 2; run.delete(); end
          2: if (e) begin
            if (run.size() != 0 && age < MAXC && absd(age, run[0]) <= TOL) begin
              run.push_back(age);
              if (run.size() == LOCK_COUNT) begin
                m_period = run[0];
                m_mode = 3;
              end
            end else begin
              run.delete();
              run.push_back(age);
            end
          end
          default: begin
            if (e) begin
              if (age >= MAXC || absd(age, m_period) > TOL) begin
                m_err = 1; m_mode = 2;
                run.delete();
                run.push_back(age);
              end
            end else if (age == 2 * m_period) begin
              m_lost = 1; m_mode = 1;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge pl_clk) begin
    check("pulse",      int'(sysref_pulse), int'(m_pulse));
    check("locked",     int'(locked),       int'(m_mode == 3));
    check("period",     int'(period),       m_period);
    check("period_err", int'(period_err),   int'(m_err));
    check("lost",       int'(lost),         int'(m_lost));
    check("edge_count", int'(edge_count),   m_ec);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pl_clk);
      #1;
    end
  endtask

  // One-cycle high pulse; next rise lands gap cycles after this one
  task automatic rise_then(input int gap);
    sysref_in = 1'b1;
    step(1);
    sysref_in = 1'b0;
    step(gap - 1);
  endtask

  task automatic rises(input int gap, input int n);
    repeat (n) rise_then(gap);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    step(3);
    check("reset_locked", int'(locked), 0);
    check("reset_ec", int'(edge_count), 0);
    reset_n = 1'b1;
    step(1);
    enable = 1'b1;
    step(2);

    // Basic lock at 8
    rises(8, 5);
    check("t1_locked", int'(locked), 1);
    check("t1_period", int'(period), 8);
    check("t1_ec", int'(edge_count), 5);

    // Jitter inside tolerance still locks
    pulse_clear();
    rise_then(8); rise_then(8); rise_then(9); rise_then(7); rise_then(8);
    check("t2_locked", int'(locked), 1);
    check("t2_period", int'(period), 8);
    check("t2_err", int'(period_err), 0);
    pulse_clear();
    rise_then(8); rise_then(8); rise_then(10);
    check("t2_nolock", int'(locked), 0);

    // Period change while locked
    pulse_clear();
    rises(8, 5);
    rise_then(12);
    sysref_in = 1'b1;
    step(1);
    check("t3_err", int'(period_err), 1);
    check("t3_unlock", int'(locked), 0);
    sysref_in = 1'b0;
    step(11);
    rises(12, 3);
    check("t3_relock", int'(locked), 1);
    check("t3_period", int'(period), 12);
    check("t3_err_sticky", int'(period_err), 1);

    // Loss of SYSREF
    pulse_clear();
    rises(8, 5);
    step(20);
    check("t4_lost", int'(lost), 1);
    check("t4_unlock", int'(locked), 0);
    rises(8, 5);
    check("t4_relock", int'(locked), 1);
    check("t4_lost_sticky", int'(lost), 1);

    // Asynchronous reset mid-lock, then enable drop
    #2 reset_n = 1'b0;
    #1;
    check("t5_pulse", int'(sysref_pulse), 0);
    check("t5_locked", int'(locked), 0);
    check("t5_period", int'(period), 0);
    check("t5_err", int'(period_err), 0);
    check("t5_lost", int'(lost), 0);
    check("t5_ec", int'(edge_count), 0);
    step(2);
    reset_n = 1'b1;
    step(1);
    rises(8, 5);
    check("t5_lock", int'(locked), 1);
    enable = 1'b0;
    step(1);
    check("t5_dis_locked", int'(locked), 0);
    check("t5_dis_period", int'(period), 8);
    rises(8, 2);
    check("t5_dis_ec", int'(edge_count), 5);
    enable = 1'b1;
    step(1);

    // Clear colliding with an edge
    rises(8, 6);
    rise_then(10);
    rise_then(8);
    check("t6_err_set", int'(period_err), 1);
    sysref_in = 1'b1;
    clear = 1'b1;
    step(1);
    check("t6_pulse", int'(sysref_pulse), 0);
    check("t6_ec", int'(edge_count), 0);
    check("t6_err", int'(period_err), 0);
    clear = 1'b0;
    sysref_in = 1'b0;
    step(7);
    rises(8, 4);
    check("t6_nolock", int'(locked), 0);
    rise_then(8);
    check("t6_relock", int'(locked), 1);

    // Stretched high level is one edge; minimum period of 2
    sysref_in = 1'b1;
    step(3);
    sysref_in = 1'b0;
    step(5);
    pulse_clear();
    rises(2, 5);
    check("t7_locked", int'(locked), 1);
    check("t7_period", int'(period), 2);
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
